// File: rtl/spi_pkg.sv
// Shared types for the SPI-to-RAM command controller: command encoding,
// FSM state encoding and the payload range check.
package spi_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        TX_HOLD
    } state_e;

    function automatic logic addr_in_range(input logic [7:0] v, input int depth);
        return int'(v) < depth;
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// SPI-slave word channel plus RAM request/response bus of spi_ram_ctrl.
interface spi_ram_ctrl_if #(parameter int ADDR_W = 8);
    logic [9:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              cmd_err;

    modport slave (
        input  rx_data, rx_valid, mem_gnt, mem_rvalid, mem_rdata,
        output tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, busy, cmd_err
    );

    modport master (
        output rx_data, rx_valid, mem_gnt, mem_rvalid, mem_rdata,
        input  tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata, busy, cmd_err
    );
endinterface

// File: rtl/spi_valid_edge.sv
// Rising-edge detector for the level-type rx_valid strobe.
module spi_valid_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o
);
    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level_i;
    end

    assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI command words into RAM reads/writes and returns read data.
// Optional feature: define SPI_ADDR_AUTO_INC_EN to post-increment wr_addr on each granted write.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_armed_q, rd_armed_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              cmd_err_q, cmd_err_d;

    logic              rise;
    logic              busy;
    cmd_e              cmd;
    logic [7:0]        payload;
    logic              pl_ok;

    spi_valid_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.rx_valid),
        .rise_o  (rise)
    );

    assign cmd     = cmd_e'(bus.rx_data[9:8]);
    assign payload = bus.rx_data[7:0];
    assign pl_ok   = addr_in_range(payload, MEM_DEPTH);
    assign busy    = !(state_q == IDLE || state_q == TX_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_armed_q <= 1'b0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_armed_q <= rd_armed_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_armed_d = rd_armed_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cmd_err_d  = 1'b0;

        // Edges arriving mid-access are dropped; the request stays untouched.
        if (rise && busy) cmd_err_d = 1'b1;

        case (state_q)
            IDLE, TX_HOLD: begin
                if (rise) begin
                    tx_valid_d = 1'b0;
                    case (cmd)
                        WR_ADDR: begin
                            if (pl_ok) wr_addr_d = payload[ADDR_W-1:0];
                            else       cmd_err_d = 1'b1;
                        end
                        WR_DATA: begin
                            wdata_d = payload;
                            state_d = WR_REQ;
                        end
                        RD_ADDR: begin
                            if (pl_ok) begin
                                rd_addr_d  = payload[ADDR_W-1:0];
                                rd_armed_d = 1'b1;
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        RD_DATA: begin
                            if (rd_armed_q) state_d   = RD_REQ;
                            else            cmd_err_d = 1'b1;
                        end
                    endcase
                end
            end
            WR_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = IDLE;
`ifdef SPI_ADDR_AUTO_INC_EN
                    wr_addr_d = (wr_addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : wr_addr_q + 1'b1;
`else
                    wr_addr_d = wr_addr_q;
`endif
                end
            end
            RD_REQ: begin
                if (bus.mem_gnt) begin
                    state_d    = RD_WAIT;
                    rd_armed_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (bus.mem_rvalid) begin
                    tx_data_d  = bus.mem_rdata;
                    tx_valid_d = 1'b1;
                    state_d    = TX_HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields come straight from registers frozen while busy, so they hold until grant.
    assign bus.mem_req   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign bus.mem_we    = (state_q == WR_REQ);
    assign bus.mem_addr  = (state_q == WR_REQ) ? wr_addr_q :
                           (state_q == RD_REQ) ? rd_addr_q : '0;
    assign bus.mem_wdata = (state_q == WR_REQ) ? wdata_q : '0;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: vector table plus hand sequences for
// held levels, busy drops, write-address wrap, reset in RD_WAIT and range errors.
module tb_spi_ram_ctrl;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_ctrl_if #(.ADDR_W(8)) bus ();
    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    spi_ram_ctrl_if #(.ADDR_W(4)) bus2 ();
    spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] pl;
        logic       err;
        logic       acc;
        logic [7:0] addr;
        int         gdly;
        int         rdly;
        logic [7:0] tx;
    } vec_t;

    vec_t       vt [14];
    logic [7:0] tbmem [256];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = {c, p};
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse2(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        bus2.rx_valid = 1'b1;
        bus2.rx_data  = {c, p};
        @(negedge clk);
        bus2.rx_valid = 1'b0;
    endtask

    // Called on the first cycle mem_req is expected; grants after gdly cycles.
    task automatic serve(input string tag, input logic we, input logic [7:0] addr,
                         input logic [7:0] wd, input int gdly, input int rdly,
                         input logic [7:0] exp_tx);
        for (int i = 0; i <= gdly; i++) begin
            chk({tag, " req"},  bus.mem_req, 1);
            chk({tag, " we"},   bus.mem_we, we);
            chk({tag, " addr"}, bus.mem_addr, addr);
            if (we) chk({tag, " wdata"}, bus.mem_wdata, wd);
            chk({tag, " busy"}, bus.busy, 1);
            if (i == gdly) bus.mem_gnt = 1'b1;
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0;
        if (we) tbmem[addr] = wd;
        chk({tag, " req_drop"}, bus.mem_req, 0);
        if (!we) begin
            for (int i = 1; i < rdly; i++) begin
                chk({tag, " wait_busy"}, bus.busy, 1);
                @(negedge clk);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = tbmem[addr];
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 8'h00;
            chk({tag, " tx_valid"}, bus.tx_valid, 1);
            chk({tag, " tx_data"},  bus.tx_data, exp_tx);
            chk({tag, " idle_busy"}, bus.busy, 0);
            repeat (2) @(negedge clk);
            chk({tag, " tx_hold"}, bus.tx_valid, 1);
        end
    endtask

    initial begin
        int nreq;
        for (int i = 0; i < 256; i++) tbmem[i] = 8'h00;

        vt[0]  = '{2'b11, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[1]  = '{2'b00, 8'h12, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[2]  = '{2'b01, 8'hAB, 1'b0, 1'b1, 8'h12, 2, 0, 8'h00};
        vt[3]  = '{2'b10, 8'h12, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[4]  = '{2'b11, 8'h00, 1'b0, 1'b1, 8'h12, 1, 3, 8'hAB};
        vt[5]  = '{2'b11, 8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[6]  = '{2'b00, 8'h34, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[7]  = '{2'b01, 8'h5C, 1'b0, 1'b1, 8'h34, 0, 0, 8'h00};
        vt[8]  = '{2'b10, 8'h34, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[9]  = '{2'b11, 8'h00, 1'b0, 1'b1, 8'h34, 0, 1, 8'h5C};
        vt[10] = '{2'b00, 8'hFF, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[11] = '{2'b01, 8'h01, 1'b0, 1'b1, 8'hFF, 1, 0, 8'h00};
        vt[12] = '{2'b10, 8'hFF, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00};
        vt[13] = '{2'b11, 8'h00, 1'b0, 1'b1, 8'hFF, 0, 2, 8'h01};

        rst = 1'b1;
        bus.rx_valid = 1'b0;   bus.rx_data = '0;
        bus.mem_gnt = 1'b0;    bus.mem_rvalid = 1'b0;  bus.mem_rdata = '0;
        bus2.rx_valid = 1'b0;  bus2.rx_data = '0;
        bus2.mem_gnt = 1'b0;   bus2.mem_rvalid = 1'b0; bus2.mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst tx_valid", bus.tx_valid, 0);
        chk("rst tx_data",  bus.tx_data, 0);
        chk("rst busy",     bus.busy, 0);
        chk("rst mem_req",  bus.mem_req, 0);
        chk("rst cmd_err",  bus.cmd_err, 0);
        chk("rst mem_addr", bus.mem_addr, 0);

        for (int v = 0; v < 14; v++) begin
            pulse(vt[v].cmd, vt[v].pl);
            chk($sformatf("v%0d cmd_err", v), bus.cmd_err, vt[v].err);
            chk($sformatf("v%0d tx_clr", v), bus.tx_valid, 0);
            if (vt[v].acc) begin
                serve($sformatf("v%0d", v), vt[v].cmd == 2'b01, vt[v].addr, vt[v].pl,
                      vt[v].gdly, vt[v].rdly, vt[v].tx);
            end else begin
                chk($sformatf("v%0d no_req", v), bus.mem_req, 0);
                chk($sformatf("v%0d busy", v), bus.busy, 0);
                @(negedge clk);
                chk($sformatf("v%0d err_1cyc", v), bus.cmd_err, 0);
            end
        end

        // rx_valid held high with a write command: only the first edge counts
        pulse(2'b00, 8'h40);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = {2'b01, 8'h66};
        bus.mem_gnt  = 1'b1;
        nreq = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) nreq++;
            chk("held cmd_err", bus.cmd_err, 0);
        end
        bus.rx_valid = 1'b0;
        bus.mem_gnt  = 1'b0;
        chk("held write_count", nreq, 1);

        // edge while WR_REQ is pending is dropped, write still completes
        pulse(2'b00, 8'h41);
        pulse(2'b01, 8'h22);
        pulse(2'b00, 8'h99);
        chk("busy_drop cmd_err", bus.cmd_err, 1);
        serve("busy_drop", 1'b1, 8'h41, 8'h22, 0, 0, 8'h00);

        // consecutive writes from 0xFF: wrap with auto-increment, else same address
        pulse(2'b00, 8'hFF);
        pulse(2'b01, 8'h11);
        serve("inc w0", 1'b1, 8'hFF, 8'h11, 0, 0, 8'h00);
        pulse(2'b01, 8'h22);
`ifdef SPI_ADDR_AUTO_INC_EN
        serve("inc w1", 1'b1, 8'h00, 8'h22, 0, 0, 8'h00);
`else
        serve("inc w1", 1'b1, 8'hFF, 8'h22, 0, 0, 8'h00);
`endif

        // reset while in RD_WAIT, then a late rvalid
        pulse(2'b10, 8'h12);
        pulse(2'b11, 8'h00);
        chk("rstwait req", bus.mem_req, 1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("rstwait in_wait", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'h5A;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("rstwait tx_valid", bus.tx_valid, 0);
        chk("rstwait tx_data",  bus.tx_data, 0);
        chk("rstwait busy",     bus.busy, 0);
        chk("rstwait mem_req",  bus.mem_req, 0);
        pulse(2'b11, 8'h00);
        chk("rstwait unarmed err", bus.cmd_err, 1);
        chk("rstwait unarmed req", bus.mem_req, 0);

        // payload range check on a 16-word instance
        pulse2(2'b00, 8'h20);
        chk("rng wr_addr err", bus2.cmd_err, 1);
        pulse2(2'b01, 8'h77);
        chk("rng keep req",  bus2.mem_req, 1);
        chk("rng keep addr", bus2.mem_addr, 4'h0);
        bus2.mem_gnt = 1'b1;
        @(negedge clk);
        bus2.mem_gnt = 1'b0;
        pulse2(2'b10, 8'h10);
        chk("rng rd_addr err", bus2.cmd_err, 1);
        pulse2(2'b11, 8'h00);
        chk("rng rd unarmed err", bus2.cmd_err, 1);
        pulse2(2'b00, 8'h0F);
        chk("rng max ok", bus2.cmd_err, 0);
        pulse2(2'b01, 8'h01);
        chk("rng max addr", bus2.mem_addr, 4'hF);
        bus2.mem_gnt = 1'b1;
        @(negedge clk);
        bus2.mem_gnt = 1'b0;
        @(negedge clk);
        chk("rng idle", bus2.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
